// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clocks one command byte plus odd parity out to the keyboard.
// Latency: INHIBIT_CYCLES of clock inhibit after the load, then 11 device clock falls, then a line-idle wait.
// Backpressure: a write that arrives while Busy is high is dropped (no queue); Busy holds the receiver off.
module ps2_host_tx #(
    parameter logic [7:0] TX_PORT_ID     = 8'h10,
    parameter int         INHIBIT_CYCLES = 12000,
    parameter int         TIMEOUT_CYCLES = 2000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] Port_ID,
    input  logic       Write_Strobe,
    input  logic [7:0] Out_Port,
    input  logic       PS2_Clock_In,
    input  logic       PS2_Data_In,
    output logic       PS2_Clock_OE,
    output logic       PS2_Data_OE,
    output logic       Busy,
    output logic [7:0] Status
);
    // One counter serves both the inhibit window and the no-clock timeout.
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_HALF = CNT_W'(INHIBIT_CYCLES / 2);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_INHIBIT   = 2'd1,
        S_SEND      = 2'd2,
        S_WAIT_IDLE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_clk_s1, r_clk_s2, r_clk_prev;
    logic             r_dat_s1, r_dat_s2;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_idx;
    logic [8:0]       r_shift;
    logic             r_dat_oe;
    logic             r_ack;
    logic             r_done;
    logic             r_ack_err;
    logic             r_timeout;
    logic             w_fall;
    logic             w_load;
    logic             w_timeout_hit;
    logic             w_clk_oe;
    logic             w_dat_oe;

    // Two-flop synchronisers for the pad inputs; idle lines read high, so reset to 1.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= PS2_Clock_In;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= PS2_Data_In;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_s2;
    assign w_load = Write_Strobe && (Port_ID == TX_PORT_ID) && (r_state == S_IDLE);

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and line-drive decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_clk_oe      = 1'b0;
        w_dat_oe      = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_load) w_state_nxt = S_INHIBIT;
            end
            S_INHIBIT: begin
                w_clk_oe = 1'b1;
                // Start bit goes out halfway through the inhibit so it is settled before release.
                w_dat_oe = (r_cnt >= INH_HALF);
                if (r_cnt == INH_LAST) w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_dat_oe = r_dat_oe;
                if (w_fall && (r_idx == 4'd10)) begin
                    w_state_nxt = S_WAIT_IDLE;
                end else if (!w_fall && (r_cnt == TO_LAST)) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_hit = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (r_clk_s2 && r_dat_s2) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_fall && (r_cnt == TO_LAST)) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_hit = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: shift register, bit index, shared counter, data drive and sticky status flags.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_dat_oe  <= 1'b0;
            r_ack     <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_shift   <= {~^Out_Port, Out_Port};
                        r_cnt     <= '0;
                        r_idx     <= '0;
                        r_dat_oe  <= 1'b0;
                        r_ack     <= 1'b0;
                        r_done    <= 1'b0;
                        r_ack_err <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                S_INHIBIT: begin
                    if (w_state_nxt == S_SEND) begin
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        r_dat_oe <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SEND, S_WAIT_IDLE: begin
                    if (w_fall) r_cnt <= '0;
                    else        r_cnt <= r_cnt + 1'b1;
                    // Host changes data while the device holds the clock low.
                    if ((r_state == S_SEND) && w_fall) begin
                        r_idx <= r_idx + 1'b1;
                        if (r_idx <= 4'd8) begin
                            r_dat_oe <= ~r_shift[r_idx];
                        end else if (r_idx == 4'd9) begin
                            r_dat_oe <= 1'b0;
                        end else begin
                            r_dat_oe <= 1'b0;
                            r_ack    <= ~r_dat_s2;
                        end
                    end
                    if (w_timeout_hit) begin
                        r_done    <= 1'b1;
                        r_ack_err <= 1'b1;
                        r_timeout <= 1'b1;
                    end else if ((r_state == S_WAIT_IDLE) && (w_state_nxt == S_IDLE)) begin
                        r_done    <= 1'b1;
                        r_ack_err <= ~r_ack;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign PS2_Clock_OE = w_clk_oe;
    assign PS2_Data_OE  = w_dat_oe;
    assign Busy         = (r_state != S_IDLE);
    assign Status       = {4'b0000, r_timeout, r_ack_err, r_done, Busy};

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector line model plus a PS/2 keyboard that clocks the frame.
// Table vectors, hand sequences (port decode, busy write, timeout, reset mid-frame) and random frames.
// Expected frames and status come from a byte-level model of the PS/2 host-to-device rules.
module tb_ps2_host_tx;
    localparam int N = 120;
    localparam int T = 2000;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] Port_ID = 8'h00;
    logic       Write_Strobe = 1'b0;
    logic [7:0] Out_Port = 8'h00;
    logic       PS2_Clock_OE, PS2_Data_OE, Busy;
    logic [7:0] Status;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       clk_line, dat_line;

    int checks = 0;
    int errors = 0;

    // Wired-AND lines with pull-ups: either side pulling low wins.
    assign clk_line = ~(PS2_Clock_OE | dev_clk_low);
    assign dat_line = ~(PS2_Data_OE | dev_dat_low);

    ps2_host_tx #(
        .TX_PORT_ID    (8'h10),
        .INHIBIT_CYCLES(N),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .Port_ID     (Port_ID),
        .Write_Strobe(Write_Strobe),
        .Out_Port    (Out_Port),
        .PS2_Clock_In(clk_line),
        .PS2_Data_In (dat_line),
        .PS2_Clock_OE(PS2_Clock_OE),
        .PS2_Data_OE (PS2_Data_OE),
        .Busy        (Busy),
        .Status      (Status)
    );

    always #5 CLK = ~CLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        bit         ack_low;
        logic       exp_parity;
        logic [7:0] exp_status;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_write(input logic [7:0] port, input logic [7:0] data);
        Port_ID      = port;
        Out_Port     = data;
        Write_Strobe = 1'b1;
        @(negedge CLK);
        Write_Strobe = 1'b0;
    endtask

    // Frame as seen on the data line after falls 0..9: data LSB first, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int b = 0; b < 8; b++) ones += int'(d[b]);
        return {1'b1, ((ones % 2) == 0), d};
    endfunction

    // Completed transfer: Done set, Ack_Error set when the device failed to pull data low.
    function automatic logic [7:0] model_status(input bit ack_low);
        return ack_low ? 8'h02 : 8'h06;
    endfunction

    // Loads a byte and plays the keyboard side. inject_k: fall at which a stray write is issued;
    // abort_k: fall after which RESET is pulsed (frame is abandoned).
    task automatic run_frame(input logic [7:0] data, input bit ack_low, input int half,
                             input int inject_k, input int abort_k,
                             output logic [9:0] bits, output logic [7:0] st);
        int i;
        int first_dat;
        bits = '0;
        st   = '0;
        do_write(8'h10, data);
        check("status_after_load", 32'(Status), 32'h01);
        i = 0;
        first_dat = -1;
        while (PS2_Clock_OE && i < N + 50) begin
            if (PS2_Data_OE && first_dat < 0) first_dat = i;
            i++;
            @(negedge CLK);
        end
        check("inhibit_len", i, N);
        check("start_bit_at", first_dat, N / 2);
        check("start_bit_held", 32'(PS2_Data_OE), 32'h1);
        wait_cycles(half);
        check("start_bit_line", 32'(dat_line), 32'h0);
        for (int k = 0; k < 11; k++) begin
            dev_clk_low = 1'b1;
            if (k == abort_k) begin
                wait_cycles(5);
                RESET = 1'b1;
                #1;
                check("reset_clk_oe", 32'(PS2_Clock_OE), 32'h0);
                check("reset_dat_oe", 32'(PS2_Data_OE), 32'h0);
                check("reset_status", 32'(Status), 32'h00);
                dev_clk_low = 1'b0;
                dev_dat_low = 1'b0;
                @(negedge CLK);
                RESET = 1'b0;
                wait_cycles(5);
                return;
            end
            if (k == inject_k) begin
                do_write(8'h10, 8'hFF);
                wait_cycles(half - 1);
            end else begin
                wait_cycles(half);
            end
            if (k < 10) bits[k] = dat_line;
            dev_clk_low = 1'b0;
            if (k == 9 && ack_low) dev_dat_low = 1'b1;
            wait_cycles(half);
        end
        dev_dat_low = 1'b0;
        i = 0;
        while (Busy && i < 100) begin
            i++;
            @(negedge CLK);
        end
        check("idle_detect_busy", 32'(Busy), 32'h0);
        check("end_lines_released", 32'({PS2_Clock_OE, PS2_Data_OE}), 32'h0);
        st = Status;
    endtask

    initial begin
        vec_t       vecs[6];
        logic [9:0] bits;
        logic [7:0] st;
        int         n;
        bit         dat_drop;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 8'h02};
        vecs[1] = '{8'hED, 1'b0, 1'b1, 8'h06};
        vecs[2] = '{8'hF4, 1'b1, 1'b0, 8'h02};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'h02};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h02};
        vecs[5] = '{8'h01, 1'b0, 1'b0, 8'h06};

        // Reset state.
        wait_cycles(3);
        check("rst_clk_oe", 32'(PS2_Clock_OE), 32'h0);
        check("rst_dat_oe", 32'(PS2_Data_OE), 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        check("rst_status", 32'(Status), 32'h00);
        RESET = 1'b0;
        wait_cycles(3);

        // Write to another port is not decoded.
        do_write(8'h11, 8'hED);
        wait_cycles(3);
        check("wrong_port_busy", 32'(Busy), 32'h0);
        check("wrong_port_clk_oe", 32'(PS2_Clock_OE), 32'h0);

        // Table vectors; the first one also gets a write of 8'hFF mid-frame that must be dropped.
        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].data, vecs[v].ack_low, 20, (v == 0) ? 3 : -1, -1, bits, st);
            check($sformatf("vec%0d_frame", v), 32'(bits), 32'({1'b1, vecs[v].exp_parity, vecs[v].data}));
            check($sformatf("vec%0d_status", v), 32'(st), 32'(vecs[v].exp_status));
        end
        wait_cycles(20);
        check("sticky_status", 32'(Status), 32'(vecs[5].exp_status));

        // Device never clocks: timeout after the inhibit plus the full timeout window.
        do_write(8'h10, 8'h00);
        n = 0;
        dat_drop = 1'b0;
        while (Busy && n < N + T + 100) begin
            if (n >= N && !PS2_Data_OE) dat_drop = 1'b1;
            n++;
            @(negedge CLK);
        end
        check("timeout_busy_len", n, N + T);
        check("timeout_start_held", 32'(dat_drop), 32'h0);
        check("timeout_lines", 32'({PS2_Clock_OE, PS2_Data_OE}), 32'h0);
        check("timeout_status", 32'(Status), 32'h0E);

        // Reset during inhibit with both lines pulled low releases them immediately.
        do_write(8'h10, 8'hA5);
        wait_cycles(N / 2 + 10);
        check("inh_both_driven", 32'({PS2_Clock_OE, PS2_Data_OE}), 32'h3);
        RESET = 1'b1;
        #1;
        check("inh_reset_lines", 32'({PS2_Clock_OE, PS2_Data_OE}), 32'h0);
        check("inh_reset_status", 32'(Status), 32'h00);
        @(negedge CLK);
        RESET = 1'b0;
        wait_cycles(5);

        // Reset after the 4th fall of an 8'hFF frame, then a clean 8'hF4 frame.
        run_frame(8'hFF, 1'b1, 20, -1, 3, bits, st);
        run_frame(8'hF4, 1'b1, 15, -1, -1, bits, st);
        check("post_reset_frame", 32'(bits), 32'({1'b1, 1'b0, 8'hF4}));
        check("post_reset_status", 32'(st), 32'h02);

        // Random bytes, ACK behaviour and device clock rates against the model.
        for (int r = 0; r < 8; r++) begin
            logic [7:0] d;
            bit         a;
            int         h;
            d = 8'($urandom_range(0, 255));
            a = 1'($urandom_range(0, 1));
            h = int'($urandom_range(8, 30));
            run_frame(d, a, h, -1, -1, bits, st);
            check($sformatf("rand%0d_frame_%02h", r, d), 32'(bits), 32'(model_frame(d)));
            check($sformatf("rand%0d_status", r), 32'(st), 32'(model_status(a)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
